sextium_mem_arbiter: RTL and testbench

Shares the single Sextium memory port between two masters.
- Master 0 is the sextium_core data/fetch path.
- Master 1 is a secondary requester, such as a loader or debug DMA.
Each master uses a req/ack handshake. The block sequences the memory strobes with a programmable wait-state count. It sits between the masters and simulated_memory or the real RAM, and drives mem_read, mem_write, addr_bus and the write data.

---
 rtl/sextium_mem_arbiter_pkg.sv | 19 +
 rtl/sextium_mem_arbiter_if.sv | 22 ++
 rtl/sextium_wait_counter.sv | 38 +++
 rtl/sextium_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sextium_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sextium_mem_arbiter_pkg.sv
// Shared types and constants for the Sextium memory arbiter and its helpers.
package sextium_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  // Arbiter FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Wait counter width: max(1, clog2(wait_cycles+1))
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sextium_mem_arbiter_if.sv
// Memory-side bus of the Sextium arbiter: strobes, address and data.
interface sextium_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] mem_bus_out;
  logic [DATA_W-1:0] mem_bus_in;

  // Arbiter drives the strobes, memory returns read data
  modport master (
    output mem_read, mem_write, addr_bus, mem_bus_out,
    input  mem_bus_in
  );

  modport slave (
    input  mem_read, mem_write, addr_bus, mem_bus_out,
    output mem_bus_in
  );
endinterface

// File: rtl/sextium_wait_counter.sv
// Loadable down-counter with zero flag; sequences memory wait states.
module sextium_wait_counter
  import sextium_mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero_c
);
  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: load wins over decrement, never underflows
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(WAIT_CYCLES);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/sextium_mem_arbiter.sv
// Two-master arbiter for the single Sextium memory port with programmable
// wait states. Optional macro SEXTIUM_ARB_ROUND_ROBIN_EN switches contention
// handling from fixed master-0 priority to alternating ownership.
module sextium_mem_arbiter
  import sextium_mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              grant,
  output logic              busy,
  sextium_mem_arbiter_if.master mem
);

  state_e            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              load_c, dec_c, cnt_zero_c, win_c;

`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;

  // On contention the master that did not own the last access wins
  assign win_c = (req0 && req1) ? ~last_q : req1;
`else
  // Master 0 always wins when it requests
  assign win_c = ~req0;
`endif

  sextium_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .load   (load_c),
    .dec    (dec_c),
    .zero_c (cnt_zero_c)
  );

  // State and output registers; reset drops strobes without a clock edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req0 || req1) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_zero_c)   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata_q;
    grant_d     = grant_q;
    load_c      = 1'b0;
    dec_c       = 1'b0;
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d     = win_c;
          addr_d      = win_c ? addr1  : addr0;
          wdata_d     = win_c ? wdata1 : wdata0;
          we_d        = win_c ? we1    : we0;
          mem_read_d  = ~we_d;
          mem_write_d = we_d;
          load_c      = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero_c) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) rdata_d = mem.mem_bus_in;
        end else begin
          dec_c = 1'b1;
        end
      end
      ST_DONE: begin
        ack0_d = ~grant_q;
        ack1_d = grant_q;
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
        last_d = grant_q;
`endif
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign mem.mem_read    = mem_read_q;
  assign mem.mem_write   = mem_write_q;
  assign mem.addr_bus    = addr_q;
  assign mem.mem_bus_out = wdata_q;
  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign rdata           = rdata_q;
  assign grant           = grant_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// Directed bench for sextium_mem_arbiter: one DUT with one wait state and a
// second with zero wait states, each with its own memory model.
module tb_sextium_mem_arbiter;

  localparam int W = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, grant, busy;
  logic [15:0] rdata;

  logic        zreq0 = 1'b0;
  logic [15:0] zaddr0 = '0;
  logic        zack0, zack1, zgrant, zbusy;
  logic [15:0] zrdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sextium_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mif ();
  sextium_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) zif ();

  sextium_mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) u_dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .grant(grant), .busy(busy), .mem(mif.master)
  );

  sextium_mem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(16), .DATA_W(16)) u_dut_w0 (
    .clock(clock), .reset(reset),
    .req0(zreq0), .we0(1'b0), .addr0(zaddr0), .wdata0(16'h0000), .ack0(zack0),
    .req1(1'b0), .we1(1'b0), .addr1(16'h0000), .wdata1(16'h0000), .ack1(zack1),
    .rdata(zrdata), .grant(zgrant), .busy(zbusy), .mem(zif.master)
  );

  // Fixed read contents for addresses never written
  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hBEEF;
      16'h0020: return 16'hCAFE;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // Memory model for the main DUT: written words override the fixed contents
  logic [15:0] wmem [0:65535];
  logic        wvld [0:65535];
  assign mif.mem_bus_in = (wvld[mif.addr_bus] === 1'b1) ? wmem[mif.addr_bus] : rom(mif.addr_bus);
  always @(posedge clock) begin
    if (mif.mem_write) begin
      wmem[mif.addr_bus] <= mif.mem_bus_out;
      wvld[mif.addr_bus] <= 1'b1;
    end
  end

  assign zif.mem_bus_in = rom(zif.addr_bus);

  task automatic test_reset();
    logic [55:0] outs;
    repeat (3) @(negedge clock);
    outs = {mif.mem_read, mif.mem_write, mif.addr_bus, mif.mem_bus_out, ack0, ack1, rdata, grant, busy};
    n_vec++;
    if (outs !== '0) begin n_err++; $display("FAIL reset_in: got %h exp 0", outs); end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      outs = {mif.mem_read, mif.mem_write, mif.addr_bus, mif.mem_bus_out, ack0, ack1, rdata, grant, busy};
      n_vec++;
      if (outs !== '0) begin n_err++; $display("FAIL reset_idle k=%0d: got %h exp 0", k, outs); end
    end
  endtask

  task automatic test_single_read();
    logic exp_s, exp_a;
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      exp_s = (k <= W + 1);
      exp_a = (k == W + 3);
      n_vec++;
      if (mif.mem_read !== exp_s) begin n_err++; $display("FAIL rd_strobe k=%0d: got %b exp %b", k, mif.mem_read, exp_s); end
      n_vec++;
      if (mif.mem_write !== 1'b0) begin n_err++; $display("FAIL rd_nowrite k=%0d: got %b exp 0", k, mif.mem_write); end
      n_vec++;
      if (ack0 !== exp_a) begin n_err++; $display("FAIL rd_ack0 k=%0d: got %b exp %b", k, ack0, exp_a); end
      if (exp_s) begin
        n_vec++;
        if (mif.addr_bus !== 16'h0010) begin n_err++; $display("FAIL rd_addr k=%0d: got %h exp 0010", k, mif.addr_bus); end
        n_vec++;
        if ({grant, busy} !== 2'b01) begin n_err++; $display("FAIL rd_grant_busy k=%0d: got %b exp 01", k, {grant, busy}); end
      end
      if (exp_a) begin
        n_vec++;
        if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_data: got %h exp beef", rdata); end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_single_write();
    logic exp_s, exp_a;
    @(negedge clock);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = 16'h1234;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      exp_s = (k <= W + 1);
      exp_a = (k == W + 3);
      n_vec++;
      if ({mif.mem_write, mif.mem_read} !== {exp_s, 1'b0}) begin
        n_err++; $display("FAIL wr_strobe k=%0d: got %b exp %b", k, {mif.mem_write, mif.mem_read}, {exp_s, 1'b0});
      end
      n_vec++;
      if ({ack1, ack0} !== {exp_a, 1'b0}) begin n_err++; $display("FAIL wr_ack k=%0d: got %b exp %b", k, {ack1, ack0}, {exp_a, 1'b0}); end
      if (exp_s) begin
        n_vec++;
        if ({mif.addr_bus, mif.mem_bus_out} !== {16'h0200, 16'h1234}) begin
          n_err++; $display("FAIL wr_bus k=%0d: got %h/%h exp 0200/1234", k, mif.addr_bus, mif.mem_bus_out);
        end
      end
      if (exp_a) begin
        n_vec++;
        if (grant !== 1'b1) begin n_err++; $display("FAIL wr_grant: got %b exp 1", grant); end
        req1 = 1'b0; we1 = 1'b0;
      end
    end
    n_vec++;
    if (wmem[16'h0200] !== 16'h1234) begin n_err++; $display("FAIL wr_mem: got %h exp 1234", wmem[16'h0200]); end
  endtask

  task automatic test_contention();
    logic exp_g [4];
    int   acks;
    int   last_c;
`ifdef SEXTIUM_ARB_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    acks = 0;
    last_c = 0;
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0101;
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      @(negedge clock);
      n_vec++;
      if ((mif.mem_read & mif.mem_write) !== 1'b0) begin n_err++; $display("FAIL ct_overlap c=%0d: both strobes high", c); end
      if (ack0 || ack1) begin
        n_vec++;
        if ({ack1, ack0} !== (exp_g[acks] ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL ct_ack n=%0d: got %b exp grant %b", acks, {ack1, ack0}, exp_g[acks]);
        end
        n_vec++;
        if (grant !== exp_g[acks]) begin n_err++; $display("FAIL ct_grant n=%0d: got %b exp %b", acks, grant, exp_g[acks]); end
        n_vec++;
        if (rdata !== rom(exp_g[acks] ? 16'h0101 : 16'h0100)) begin
          n_err++; $display("FAIL ct_rdata n=%0d: got %h exp %h", acks, rdata, rom(exp_g[acks] ? 16'h0101 : 16'h0100));
        end
        if (acks > 0) begin
          n_vec++;
          if (c - last_c != W + 3) begin n_err++; $display("FAIL ct_spacing n=%0d: got %0d exp %0d", acks, c - last_c, W + 3); end
        end
        last_c = c;
        acks++;
        if (acks == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    n_vec++;
    if (acks != 4) begin n_err++; $display("FAIL ct_timeout: got %0d acks exp 4", acks); end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_req_drop();
    logic exp_s, exp_a;
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      exp_s = (k <= W + 1);
      exp_a = (k == W + 3);
      n_vec++;
      if (mif.mem_read !== exp_s) begin n_err++; $display("FAIL drop_strobe k=%0d: got %b exp %b", k, mif.mem_read, exp_s); end
      n_vec++;
      if (ack0 !== exp_a) begin n_err++; $display("FAIL drop_ack0 k=%0d: got %b exp %b", k, ack0, exp_a); end
      if (exp_s) begin
        n_vec++;
        if (mif.addr_bus !== 16'h0020) begin n_err++; $display("FAIL drop_addr k=%0d: got %h exp 0020", k, mif.addr_bus); end
      end
      if (exp_a) begin
        n_vec++;
        if (rdata !== 16'hCAFE) begin n_err++; $display("FAIL drop_rdata: got %h exp cafe", rdata); end
      end
      if (k == 1) begin req0 = 1'b0; addr0 = 16'hFFFF; end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030;
    @(negedge clock);
    n_vec++;
    if ({mif.mem_read, busy} !== 2'b11) begin n_err++; $display("FAIL rst_pre: got %b exp 11", {mif.mem_read, busy}); end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({mif.mem_read, busy, mif.addr_bus} !== 18'h0) begin
      n_err++; $display("FAIL rst_async: got %b/%b/%h exp 0/0/0000", mif.mem_read, busy, mif.addr_bus);
    end
    req0 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_vec++;
      if ({ack0, ack1, busy, mif.mem_read} !== 4'b0) begin
        n_err++; $display("FAIL rst_after k=%0d: got %b exp 0000", k, {ack0, ack1, busy, mif.mem_read});
      end
    end
  endtask

  task automatic test_wait0();
    logic exp_s, exp_a;
    @(negedge clock);
    zreq0 = 1'b1; zaddr0 = 16'h0001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      exp_s = (k == 1);
      exp_a = (k == 3);
      n_vec++;
      if ({zif.mem_read, zif.mem_write} !== {exp_s, 1'b0}) begin
        n_err++; $display("FAIL w0_strobe k=%0d: got %b exp %b", k, {zif.mem_read, zif.mem_write}, {exp_s, 1'b0});
      end
      n_vec++;
      if (zack0 !== exp_a) begin n_err++; $display("FAIL w0_ack k=%0d: got %b exp %b", k, zack0, exp_a); end
      if (exp_a) begin
        n_vec++;
        if (zrdata !== 16'h5A5B) begin n_err++; $display("FAIL w0_rdata: got %h exp 5a5b", zrdata); end
        zreq0 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_req_drop();
    test_reset_mid();
    test_wait0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
